// File: rtl/pipe_pkg.sv
// Shared pipeline types and PC helpers for the fetch-redirect controller.
package pipe_pkg;

    localparam int unsigned PC_W    = 12;
    localparam int unsigned IDX_LSB = 0;
    localparam int unsigned IDX_MSB = 3;
    localparam int unsigned TAG_LSB = 4;
    localparam int unsigned TAG_MSB = PC_W - 1;

    typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;
    typedef enum logic {ALLOC = 1'b0, TRAIN = 1'b1} tbl_op_t;

    typedef struct packed {
        logic            we;
        tbl_op_t         op;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
    } tbl_wr_t;

    typedef struct packed {
        logic            vld;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
    } alloc_buf_t;

    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Pipeline-side signals of the redirect controller: fetch, ID/EX branch info and table port.
interface branch_redirect_ctrl_if;
    import pipe_pkg::*;

    logic            stall_in;
    logic [PC_W-1:0] if_pc;
    logic            pred_hit;
    logic [PC_W-1:0] pred_target;
    logic            id_is_branch;
    logic [PC_W-1:0] id_pc;
    logic [PC_W-1:0] id_target;
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_taken;
    logic [PC_W-1:0] ex_pc;
    logic [PC_W-1:0] ex_target;
    logic            ex_pred_taken;
    logic [PC_W-1:0] ex_pred_target;

    logic [PC_W-1:0] next_pc;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            tbl_we;
    tbl_op_t         tbl_op;
    logic [PC_W-1:0] tbl_pc;
    logic [PC_W-1:0] tbl_target;
    logic            tbl_taken;

    modport master (
        output stall_in, if_pc, pred_hit, pred_target, id_is_branch, id_pc, id_target,
               ex_valid, ex_is_branch, ex_taken, ex_pc, ex_target, ex_pred_taken, ex_pred_target,
        input  next_pc, flush_if_id, flush_id_ex, tbl_we, tbl_op, tbl_pc, tbl_target, tbl_taken
    );

    modport slave (
        input  stall_in, if_pc, pred_hit, pred_target, id_is_branch, id_pc, id_target,
               ex_valid, ex_is_branch, ex_taken, ex_pc, ex_target, ex_pred_taken, ex_pred_target,
        output next_pc, flush_if_id, flush_id_ex, tbl_we, tbl_op, tbl_pc, tbl_target, tbl_taken
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge CLK) begin
        if (!RSTn)
            q <= '0;
        else if (inc && (q != {CNT_W{1'b1}}))
            q <= q + CNT_W'(1);
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Fetch-redirect controller: next-PC select, mispredict flush/recovery and
// arbitration of BTB allocations and BHT training onto one predictor write port.
module branch_redirect_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned RECOV_CYC = 2
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    branch_redirect_ctrl_if.slave bus,
    output logic [CNT_W-1:0]     br_cnt,
    output logic [CNT_W-1:0]     mispred_cnt,
    output logic [CNT_W-1:0]     alloc_drop_cnt
);

    localparam int unsigned RC_W = (RECOV_CYC > 1) ? $clog2(RECOV_CYC) : 1;

    state_t          state_q, state_d;
    logic [RC_W-1:0] rc_q, rc_d;
    tbl_wr_t         tbl_q, tbl_d;
    alloc_buf_t      buf_q, buf_d;
    logic            ex_ok, mispred, alloc_req, drop;

    // Everything is qualified by RSTn so the combinational outputs read as idle during reset.
    assign ex_ok     = RSTn && bus.ex_valid && bus.ex_is_branch && (state_q == RUN);
    assign mispred   = ex_ok && ((bus.ex_taken != bus.ex_pred_taken) ||
                                 (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
    assign alloc_req = RSTn && bus.id_is_branch && (state_q == RUN) && !mispred;

    // Next fetch PC: a redirect overrides stall, stall overrides prediction.
    always_comb begin
        bus.next_pc = '0;
        if (!RSTn)
            bus.next_pc = '0;
        else if (mispred)
            bus.next_pc = bus.ex_taken ? bus.ex_target : pc_plus4(bus.ex_pc);
        else if (bus.stall_in)
            bus.next_pc = bus.if_pc;
        else if (bus.pred_hit)
            bus.next_pc = bus.pred_target;
        else
            bus.next_pc = pc_plus4(bus.if_pc);
    end

    assign bus.flush_if_id = mispred;
    assign bus.flush_id_ex = mispred;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= RUN;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        case (state_q)
            RUN: begin
                if (mispred) begin
                    state_d = RECOVER;
                    rc_d    = RC_W'(RECOV_CYC - 1);
                end
            end
            RECOVER: begin
                if (rc_q == '0)
                    state_d = RUN;
                else
                    rc_d = rc_q - RC_W'(1);
            end
        endcase
    end

    // TRAIN always wins the port; a displaced ALLOC parks in the one-entry buffer.
    always_comb begin
        tbl_d    = '0;
        tbl_d.op = ALLOC;
        buf_d    = buf_q;
        drop     = 1'b0;
        if (ex_ok) begin
            tbl_d = '{we: 1'b1, op: TRAIN, pc: bus.ex_pc, target: bus.ex_target, taken: bus.ex_taken};
            if (alloc_req) begin
                drop  = buf_q.vld;
                buf_d = '{vld: 1'b1, pc: bus.id_pc, target: bus.id_target};
            end
        end else if (buf_q.vld) begin
            tbl_d = '{we: 1'b1, op: ALLOC, pc: buf_q.pc, target: buf_q.target, taken: 1'b0};
            if (alloc_req)
                buf_d = '{vld: 1'b1, pc: bus.id_pc, target: bus.id_target};
            else
                buf_d.vld = 1'b0;
        end else if (alloc_req) begin
            tbl_d = '{we: 1'b1, op: ALLOC, pc: bus.id_pc, target: bus.id_target, taken: 1'b0};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            tbl_q <= '0;
            buf_q <= '0;
        end else begin
            tbl_q <= tbl_d;
            buf_q <= buf_d;
        end
    end

    assign bus.tbl_we     = tbl_q.we && RSTn;
    assign bus.tbl_op     = tbl_q.op;
    assign bus.tbl_pc     = tbl_q.pc;
    assign bus.tbl_target = tbl_q.target;
    assign bus.tbl_taken  = tbl_q.taken;

    sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .CLK (CLK), .RSTn(RSTn), .inc(ex_ok), .q(br_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .CLK (CLK), .RSTn(RSTn), .inc(mispred), .q(mispred_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .CLK (CLK), .RSTn(RSTn), .inc(drop), .q(alloc_drop_cnt)
    );

endmodule
